uart_cmd_link: RTL

Parametrised UART command master: serialises a multi-byte command onto TX, then collects a multi-byte response from RX under a timeout. It supersedes the fixed 3-byte receive / 1-byte transmit pairing. It sits between the DSO command sequencer and the external serial link. Baud generation and framing for both directions are built in, with configurable baud divisor, command length and response length.

---
 rtl/uart_cmd_pkg.sv | 21 ++
 rtl/uart_rx_core.sv | 82 ++++++++
 rtl/uart_cmd_link.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and sizing helpers for the UART command link.
// UART_CMD_PARITY_EN selects 11-bit frames with an even-parity bit.
package uart_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      TX_BYTE,
      RSP
   } state_t;

`ifdef UART_CMD_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Purpose: UART receiver (sync, start detect, mid-bit sampling, stop/parity check; UART_CMD_PARITY_EN).
// Latency: byte_vld/err_pls pulse two cycles plus half a bit after the stop bit begins.
// Backpressure: none; the consumer must take byte_dat on the byte_vld pulse.
module uart_rx_core
   import uart_cmd_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       byte_vld,
   output logic [7:0] byte_dat,
   output logic       err_pls
);

   localparam int CW = cnt_width(BAUD_DIV);
   localparam logic [CW-1:0] HALF_M1  = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(BAUD_DIV - 1);
   localparam logic [3:0]    STOP_IDX = 4'(FRAME_BITS - 1);

   logic          rx_s1, rx_s2, rx_s3;
   logic          active;
   logic [CW-1:0] cnt;
   logic [3:0]    idx;
   logic [7:0]    shreg;
   logic          par_bad;
   logic          tick;

   assign tick     = active && (cnt == '0);
   assign byte_dat = shreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         active   <= 1'b0;
         cnt      <= '0;
         idx      <= '0;
         shreg    <= '0;
         par_bad  <= 1'b0;
         byte_vld <= 1'b0;
         err_pls  <= 1'b0;
      end else begin
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
         byte_vld <= 1'b0;
         err_pls  <= 1'b0;
         if (!active) begin
            if (rx_s3 && !rx_s2) begin
               active  <= 1'b1;
               cnt     <= HALF_M1;
               idx     <= '0;
               par_bad <= 1'b0;
            end
         end else if (!tick) begin
            cnt <= cnt - 1'b1;
         end else begin
            cnt <= FULL_M1;
            idx <= idx + 4'd1;
            // A start bit that has gone high again by mid-bit is a glitch.
            if (idx == 4'd0) begin
               if (rx_s2) active <= 1'b0;
            end else if (idx <= 4'd8) begin
               shreg <= {rx_s2, shreg[7:1]};
            end else if (idx == STOP_IDX) begin
               active <= 1'b0;
               if (!rx_s2 || par_bad) err_pls  <= 1'b1;
               else                   byte_vld <= 1'b1;
            end
`ifdef UART_CMD_PARITY_EN
            else begin
               par_bad <= (^shreg) ^ rx_s2;
            end
`endif
         end
      end
   end

endmodule

// File: rtl/uart_cmd_link.sv
// Purpose: UART command master, sends CMD_BYTES then collects RSP_BYTES under timeout (UART_CMD_PARITY_EN).
// Latency: TX start bit the cycle after an accepted snd_cmd; resp_rdy at the last byte's mid-stop sample.
// Backpressure: snd_cmd is dropped while busy; resp_rdy held until clr_resp_rdy or the next command.
module uart_cmd_link
   import uart_cmd_pkg::*;
#(
   parameter int BAUD_DIV    = 2604,
   parameter int CMD_BYTES   = 3,
   parameter int RSP_BYTES   = 1,
   parameter int TIMEOUT_CYC = 1048576
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          snd_cmd,
   input  logic [8*CMD_BYTES-1:0]                        cmd,
   input  logic                                          RX,
   input  logic                                          clr_resp_rdy,
   output logic                                          TX,
   output logic                                          busy,
   output logic [((RSP_BYTES > 0) ? 8*RSP_BYTES : 8)-1:0] resp,
   output logic                                          resp_rdy,
   output logic                                          timeout,
   output logic                                          frm_err
);

   localparam int CW = cnt_width(BAUD_DIV);
   localparam int TW = cnt_width(TIMEOUT_CYC);
   localparam int RW = (RSP_BYTES > 0) ? 8*RSP_BYTES : 8;
   localparam logic [CW-1:0] FULL_M1  = CW'(BAUD_DIV - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [3:0]    STOP_IDX = 4'(FRAME_BITS - 1);
   localparam logic [3:0]    CMD_LAST = 4'(CMD_BYTES - 1);
   localparam logic [3:0]    RSP_LAST = 4'((RSP_BYTES > 0) ? RSP_BYTES - 1 : 0);

   state_t                 state_q, state_d;
   logic [CW-1:0]          bcnt;
   logic [3:0]             bit_idx, byte_idx, rsp_idx;
   logic [8*CMD_BYTES-1:0] cmd_sr;
   logic [TW-1:0]          tmo_cnt;
   logic [7:0]             top_byte;
   logic                   accept, bit_end, rsp_take, rsp_done, tmo_fire, tx_bit;
   logic                   rx_vld, rx_err;
   logic [7:0]             rx_dat;

   uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (RX),
      .byte_vld (rx_vld),
      .byte_dat (rx_dat),
      .err_pls  (rx_err)
   );

   assign top_byte = cmd_sr[8*CMD_BYTES-1 -: 8];
   assign busy     = (state_q != IDLE);
   assign TX       = tx_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      bit_end  = 1'b0;
      rsp_take = 1'b0;
      rsp_done = 1'b0;
      tmo_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (snd_cmd) begin
               accept  = 1'b1;
               state_d = TX_BYTE;
            end
         end
         TX_BYTE: begin
            bit_end = (bcnt == FULL_M1);
            if (bit_end && bit_idx == STOP_IDX && byte_idx == CMD_LAST)
               state_d = (RSP_BYTES > 0) ? RSP : IDLE;
         end
         RSP: begin
            rsp_take = rx_vld;
            if (rx_vld) begin
               if (rsp_idx == RSP_LAST) begin
                  rsp_done = 1'b1;
                  state_d  = IDLE;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_fire = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Serial line is a pure function of the frame position, so reset forces it high at once.
   always_comb begin
      tx_bit = 1'b1;
      if (state_q == TX_BYTE) begin
         if (bit_idx == 4'd0)       tx_bit = 1'b0;
         else if (bit_idx <= 4'd8)  tx_bit = top_byte[3'(bit_idx - 4'd1)];
`ifdef UART_CMD_PARITY_EN
         else if (bit_idx == 4'd9)  tx_bit = ^top_byte;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt     <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         rsp_idx  <= '0;
         cmd_sr   <= '0;
         tmo_cnt  <= '0;
         resp     <= '0;
         resp_rdy <= 1'b0;
         timeout  <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         if (accept) begin
            cmd_sr   <= cmd;
            bcnt     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            timeout  <= 1'b0;
            frm_err  <= 1'b0;
         end
         if (state_q == TX_BYTE) begin
            if (!bit_end) begin
               bcnt <= bcnt + 1'b1;
            end else begin
               bcnt <= '0;
               if (bit_idx == STOP_IDX) begin
                  bit_idx  <= '0;
                  byte_idx <= byte_idx + 4'd1;
                  cmd_sr   <= cmd_sr << 8;
               end else begin
                  bit_idx <= bit_idx + 4'd1;
               end
            end
         end
         // Timeout window restarts on RSP entry and on every accepted byte.
         if (state_q != RSP) begin
            tmo_cnt <= '0;
            rsp_idx <= '0;
         end else if (rsp_take) begin
            tmo_cnt <= '0;
            rsp_idx <= rsp_idx + 4'd1;
            resp    <= RW'({resp, rx_dat});
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (tmo_fire) timeout <= 1'b1;
         if (state_q == RSP && rx_err) frm_err <= 1'b1;
         if (rsp_done)                       resp_rdy <= 1'b1;
         else if (clr_resp_rdy || accept)    resp_rdy <= 1'b0;
      end
   end

endmodule
